// File: rtl/auction_pkg.sv
// ============================================================================
// auction_pkg : shared FSM state type and tie-break rule for the auction block
// Revision    : 1.0
// ============================================================================
`default_nettype none

package auction_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Equal bids keep the earlier (lower) id when set.
    localparam bit LOWEST_ID_WINS = 1'b1;

endpackage

`default_nettype wire

// File: rtl/auction_bid_table.sv
// ============================================================================
// auction_bid_table : 2**N x W bid storage with valid bits, one write port,
//                     one indexed combinational read port and a clear-all
// Revision          : 1.0
// ============================================================================
`default_nettype none

module auction_bid_table #(
    parameter int N = 2,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [N-1:0] wr_idx,
    input  logic [W-1:0] wr_data,
    input  logic [N-1:0] rd_idx,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    input  logic         clr_all
);

    localparam int DEPTH = 2**N;

    logic [W-1:0] r_value [DEPTH];
    logic         r_valid [DEPTH];

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_value[g] <= '0;
                    r_valid[g] <= 1'b0;
                end else if (clr_all) begin
                    r_valid[g] <= 1'b0;
                end else if (wr_en && (wr_idx == N'(g))) begin
                    r_value[g] <= wr_data;
                    r_valid[g] <= 1'b1;
                end
            end
        end
    endgenerate

    assign rd_data  = r_value[rd_idx];
    assign rd_valid = r_valid[rd_idx];

endmodule

`default_nettype wire

// File: rtl/auction_ctrl.sv
// ============================================================================
// auction_ctrl : collects bids per bidder id and resolves the highest bid by
//                a sequential one-comparator scan of the bid table
// Revision     : 1.0
// ============================================================================
`default_nettype none

module auction_ctrl
    import auction_pkg::*;
#(
    parameter int N = 2,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bid_valid,
    output logic         bid_ready,
    input  logic [N-1:0] bid_id,
    input  logic [W-1:0] bid_value,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] winner,
    output logic [W-1:0] winning_bid,
    output logic         any_bid
);

    // The scan counter runs one past the last entry; that extra cycle hands
    // the completed running maximum over to the result registers.
    localparam logic [N:0] c_scan_end = (N+1)'(2**N);

    state_t       r_state;
    state_t       w_next_state;
    logic [N:0]   r_idx;
    logic [W-1:0] r_max_value;
    logic [N-1:0] r_max_id;
    logic         r_max_found;
    logic [N-1:0] r_winner;
    logic [W-1:0] r_winning_bid;
    logic         r_any_bid;

    logic [W-1:0] w_rd_data;
    logic         w_rd_valid;
    logic         w_bid_accept;
    logic         w_scan_end;
    logic         w_entry_live;
    logic         w_take;

    auction_bid_table #(
        .N (N),
        .W (W)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (w_bid_accept),
        .wr_idx   (bid_id),
        .wr_data  (bid_value),
        .rd_idx   (r_idx[N-1:0]),
        .rd_data  (w_rd_data),
        .rd_valid (w_rd_valid),
        .clr_all  (r_state == DONE)
    );

    assign bid_ready    = (r_state == IDLE);
    assign busy         = (r_state == SCAN);
    assign done         = (r_state == DONE);
    assign w_bid_accept = bid_valid && bid_ready;
    assign w_scan_end   = (r_state == SCAN) && (r_idx == c_scan_end);
    assign w_entry_live = (r_state == SCAN) && !r_idx[N] && w_rd_valid;
    assign w_take       = w_entry_live &&
                          (!r_max_found || (w_rd_data > r_max_value) ||
                           (!LOWEST_ID_WINS && (w_rd_data == r_max_value)));

    assign winner      = r_winner;
    assign winning_bid = r_winning_bid;
    assign any_bid     = r_any_bid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = SCAN;
            SCAN:    if (w_scan_end) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx         <= '0;
            r_max_value   <= '0;
            r_max_id      <= '0;
            r_max_found   <= 1'b0;
            r_winner      <= '0;
            r_winning_bid <= '0;
            r_any_bid     <= 1'b0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_idx       <= '0;
                r_max_value <= '0;
                r_max_id    <= '0;
                r_max_found <= 1'b0;
            end else if (r_state == SCAN) begin
                if (!r_idx[N]) begin
                    r_idx <= r_idx + 1'b1;
                end
                if (w_take) begin
                    r_max_value <= w_rd_data;
                    r_max_id    <= r_idx[N-1:0];
                    r_max_found <= 1'b1;
                end
            end
            if (w_scan_end) begin
                r_winner      <= r_max_id;
                r_winning_bid <= r_max_value;
                r_any_bid     <= r_max_found;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_auction_ctrl.sv
// ============================================================================
// tb_auction_ctrl : self-checking bench for auction_ctrl (N=2, W=2)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_auction_ctrl;

    localparam int N = 2;
    localparam int W = 2;

    logic         clk;
    logic         rst_n;
    logic         bid_valid;
    logic         bid_ready;
    logic [N-1:0] bid_id;
    logic [W-1:0] bid_value;
    logic         start;
    logic         busy;
    logic         done;
    logic [N-1:0] winner;
    logic [W-1:0] winning_bid;
    logic         any_bid;

    int checks = 0;
    int errors = 0;

    // Reference table: what the spec says has been recorded since last DONE.
    logic         m_valid [4];
    logic [W-1:0] m_value [4];

    auction_ctrl #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bid_valid   (bid_valid),
        .bid_ready   (bid_ready),
        .bid_id      (bid_id),
        .bid_value   (bid_value),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .winner      (winner),
        .winning_bid (winning_bid),
        .any_bid     (any_bid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] v;
        logic [7:0] vals;
        logic [1:0] ew;
        logic [1:0] eb;
        logic       ea;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    endtask

    // Highest value among recorded bids, then the lowest id holding it.
    task automatic model_expect(output logic [1:0] w, output logic [1:0] b, output logic a);
        int best;
        best = -1;
        for (int i = 0; i < 4; i++)
            if (m_valid[i] && int'(m_value[i]) > best) best = int'(m_value[i]);
        a = (best >= 0);
        b = a ? 2'(best) : 2'd0;
        w = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m_valid[i] && int'(m_value[i]) == best) w = 2'(i);
    endtask

    task automatic bid(input logic [1:0] id, input logic [1:0] val);
        @(negedge clk);
        check("bid_ready idle", bid_ready, 1);
        bid_valid = 1'b1;
        bid_id    = id;
        bid_value = val;
        m_valid[id] = 1'b1;
        m_value[id] = val;
        @(negedge clk);
        bid_valid = 1'b0;
    endtask

    task automatic resolve(input logic sb, input logic [1:0] sid, input logic [1:0] sval,
                           input logic scan_bid, input logic [1:0] ew, input logic [1:0] eb,
                           input logic ea, input string tag);
        int n;
        bit got;
        @(negedge clk);
        start     = 1'b1;
        bid_valid = sb;
        bid_id    = sid;
        bid_value = sval;
        got = 1'b0;
        n   = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            start     = 1'b0;
            bid_valid = 1'b0;
            if (n == 1) check({tag, " busy"}, busy, 1);
            if (scan_bid && n == 2) begin
                check({tag, " bid_ready scan"}, bid_ready, 0);
                bid_valid = 1'b1;
                bid_id    = 2'd2;
                bid_value = 2'd3;
            end
            if (done) got = 1'b1;
        end
        bid_valid = 1'b0;
        check({tag, " latency"}, got ? n : 99, 6);
        check({tag, " winner"}, winner, ew);
        check({tag, " winning_bid"}, winning_bid, eb);
        check({tag, " any_bid"}, any_bid, ea);
        model_clear();
        @(negedge clk);
        check({tag, " done pulse"}, done, 0);
        check({tag, " ready after"}, bid_ready, 1);
    endtask

    vec_t vecs [7];

    initial begin
        logic [1:0] ew, eb, rid, rval, sid, sval;
        logic       ea, same;
        int         nb;
        bit         saw_done;

        vecs[0] = '{v: 4'b1111, vals: 8'b00_10_11_01, ew: 2'd1, eb: 2'd3, ea: 1'b1};
        vecs[1] = '{v: 4'b1010, vals: 8'b10_00_10_00, ew: 2'd1, eb: 2'd2, ea: 1'b1};
        vecs[2] = '{v: 4'b0000, vals: 8'b00_00_00_00, ew: 2'd0, eb: 2'd0, ea: 1'b0};
        vecs[3] = '{v: 4'b0000, vals: 8'b11_11_11_11, ew: 2'd0, eb: 2'd0, ea: 1'b0};
        vecs[4] = '{v: 4'b1001, vals: 8'b11_00_00_11, ew: 2'd0, eb: 2'd3, ea: 1'b1};
        vecs[5] = '{v: 4'b0100, vals: 8'b00_00_00_00, ew: 2'd2, eb: 2'd0, ea: 1'b1};
        vecs[6] = '{v: 4'b1000, vals: 8'b01_00_00_00, ew: 2'd3, eb: 2'd1, ea: 1'b1};

        model_clear();
        rst_n = 1'b0; bid_valid = 1'b0; bid_id = '0; bid_value = '0; start = 1'b0;
        repeat (2) @(negedge clk);
        check("reset bid_ready", bid_ready, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset winner", winner, 0);
        check("reset winning_bid", winning_bid, 0);
        check("reset any_bid", any_bid, 0);
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < 4; i++)
                if (vecs[k].v[i]) bid(2'(i), vecs[k].vals[i*2 +: 2]);
            resolve(1'b0, 2'd0, 2'd0, 1'b0, vecs[k].ew, vecs[k].eb, vecs[k].ea, $sformatf("vec%0d", k));
        end

        // Rebid overwrites the earlier value for the same id.
        bid(2'd0, 2'd3);
        bid(2'd0, 2'd0);
        bid(2'd1, 2'd1);
        resolve(1'b0, 2'd0, 2'd0, 1'b0, 2'd1, 2'd1, 1'b1, "rebid");

        // Bid offered during SCAN is dropped; result holds afterwards.
        bid(2'd0, 2'd1);
        resolve(1'b0, 2'd0, 2'd0, 1'b1, 2'd0, 2'd1, 1'b1, "scanbid");
        repeat (3) @(negedge clk);
        check("hold winner", winner, 0);
        check("hold winning_bid", winning_bid, 1);
        check("hold any_bid", any_bid, 1);
        resolve(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, "after scanbid");

        // Bid in the same cycle as start is included.
        bid(2'd0, 2'd2);
        resolve(1'b1, 2'd3, 2'd3, 1'b0, 2'd3, 2'd3, 1'b1, "same cycle");

        // Reset mid-scan: outputs zero at once, no done, table emptied.
        bid(2'd1, 2'd3);
        resolve(1'b0, 2'd0, 2'd0, 1'b0, 2'd1, 2'd3, 1'b1, "pre reset");
        bid(2'd2, 2'd2);
        @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk) start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset winner", winner, 0);
        check("midreset winning_bid", winning_bid, 0);
        check("midreset any_bid", any_bid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        check("release bid_ready", bid_ready, 1);
        saw_done = 1'b0;
        repeat (10) @(negedge clk) if (done) saw_done = 1'b1;
        check("no done after reset", saw_done, 0);
        resolve(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, "post reset");

        // Randomized rounds against the reference table.
        for (int r = 0; r < 30; r++) begin
            nb = $urandom_range(0, 6);
            for (int j = 0; j < nb; j++) begin
                rid  = 2'($urandom);
                rval = 2'($urandom);
                bid(rid, rval);
            end
            same = ($urandom_range(0, 2) == 0);
            sid  = 2'($urandom);
            sval = 2'($urandom);
            if (same) begin
                m_valid[sid] = 1'b1;
                m_value[sid] = sval;
            end
            model_expect(ew, eb, ea);
            resolve(same, sid, sval, (r % 5) == 0, ew, eb, ea, $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/auction_ctrl.md
AUCTION_CTRL -- requirements
Module: auction_ctrl

Interface
REQ-001 Parameter N, default 2: log2 of the bidder count; 2**N bidders, ids 0..2**N-1.
REQ-002 Parameter W, default 2: bid value width in bits, unsigned.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port bid_valid, input, 1: a bid is offered this cycle.
REQ-006 Port bid_ready, output, 1: the block accepts bids this cycle.
REQ-007 Port bid_id, input, N: bidder index of the offered bid.
REQ-008 Port bid_value, input, W: offered bid value.
REQ-009 Port start, input, 1: request to resolve the auction.
REQ-010 Port busy, output, 1: the block is resolving (SCAN state).
REQ-011 Port done, output, 1: one-cycle pulse, result valid and updated.
REQ-012 Port winner, output, N: id of the winning bidder.
REQ-013 Port winning_bid, output, W: value of the winning bid.
REQ-014 Port any_bid, output, 1: at least one bid was recorded in the resolved round.

Function
REQ-015 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-016 The bid table SHALL hold 2**N entries, each a W-bit value plus a valid bit.
REQ-017 bid_ready SHALL be 1 in IDLE and 0 in SCAN and DONE.
REQ-018 A bid SHALL be accepted when bid_valid and bid_ready are both 1: entry[bid_id] = bid_value, valid = 1.
REQ-019 Rebidding the same id before resolution SHALL overwrite the earlier value.
REQ-020 bid_valid while bid_ready is 0 SHALL be ignored, with no table change.
REQ-021 start in IDLE SHALL move the FSM to SCAN on the next edge; start in SCAN or DONE SHALL be ignored.
REQ-022 A bid accepted in the same cycle as start SHALL be written and included in the resolution.
REQ-023 SCAN SHALL use one W-bit comparator, examining entry index i = 0..2**N-1, one entry per cycle, in ascending order.
REQ-024 SCAN SHALL maintain a running maximum (value, id, found flag); a valid entry SHALL replace it when found = 0 or its value is strictly greater than the current maximum.
REQ-025 Ties SHALL therefore resolve to the lowest id; invalid entries SHALL be skipped.
REQ-026 After index 2**N-1, the FSM SHALL enter DONE for exactly one cycle, then return to IDLE.
REQ-027 In DONE, the block SHALL:
 - assert done = 1;
 - register winner, winning_bid and any_bid from the running maximum;
 - clear all table valid bits.
REQ-028 Latency: start sampled at edge t gives done = 1 in the cycle after edge t + 2**N + 1, i.e. 2**N + 2 cycles.
REQ-029 With no valid entries, the block SHALL output any_bid = 0, winner = 0, winning_bid = 0.
REQ-030 winner, winning_bid and any_bid SHALL hold their values until the next DONE.
REQ-031 The id counter SHALL be N+1 bits wide so that the final index is detected without wrap-around aliasing.

Reset
REQ-032 rst_n = 0 SHALL immediately force:
 - state IDLE;
 - all valid bits 0;
 - winner 0, winning_bid 0, any_bid 0;
 - done 0, busy 0.
REQ-033 Reset asserted mid-SCAN SHALL abort the round with no done pulse; after release, bid_ready = 1 in the first cycle.

Structure
REQ-034 Package auction_pkg SHALL define the FSM state type (IDLE, SCAN, DONE) and the tie-rule constant LOWEST_ID_WINS.
REQ-035 The block SHALL contain one sub-module, auction_bid_table: 2**N x W storage plus valid bits, one write port, one indexed read port, and a synchronous clear-all.
REQ-036 The comparator and running-maximum registers SHALL stay in auction_ctrl.

Verification
REQ-037 N=2, W=2; bids id0=1, id1=3, id2=2, id3=0, then start -> done 6 cycles later; winner=1, winning_bid=3, any_bid=1.
REQ-038 Tie: id1=2, id3=2, others absent, start -> winner=1, winning_bid=2.
REQ-039 No bids, start -> done pulse; any_bid=0, winner=0, winning_bid=0; a second start resolves a fresh, empty table.
REQ-040 bid id2=3 offered during SCAN -> bid_ready=0; result excludes it; prior result id0=1 stays winner.
REQ-041 Bid id3=3 in the same cycle as start, table otherwise id0=2 -> winner=3, winning_bid=3.
REQ-042 rst_n pulsed low at SCAN cycle 2 -> outputs zero immediately, no done, bid_ready=1 after release, table empty.
